// File: rtl/load_store_unit.sv
// Load/store front end for the 64x32 word data memory.
// Handles alignment, sub-word read-modify-write and load extension.
module load_store_unit #(
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_is_store,
  input  logic [1:0]        i_req_size,
  input  logic              i_req_signed,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [31:0]       i_req_wdata,
  output logic              o_load_valid,
  output logic [31:0]       o_load_data,
  output logic              o_store_done,
  output logic              o_align_fault,
  output logic [ADDR_W-3:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_mem_read,
  output logic              o_mem_write,
  input  logic [31:0]       i_mem_rdata
);

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_LD_READ    = 3'd1;
  localparam logic [2:0] S_LD_EXTRACT = 3'd2;
  localparam logic [2:0] S_ST_WRITE   = 3'd3;
  localparam logic [2:0] S_RMW_READ   = 3'd4;
  localparam logic [2:0] S_RMW_WRITE  = 3'd5;
  localparam logic [2:0] S_FAULT      = 3'd6;

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [31:0]       r_wdata;
  logic              r_load_valid;
  logic              r_store_done;
  logic [31:0]       r_load_data;

  logic [2:0]  w_next;
  logic        w_legal;
  logic        w_accept;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_ext;
  logic [31:0] w_merge;
  logic [4:0]  w_byte_sh;
  logic [4:0]  w_half_sh;

  assign o_req_ready = (r_state == S_IDLE) & ~i_rst;
  assign w_accept    = i_req_valid & o_req_ready;
  assign w_byte_sh   = {r_addr[1:0], 3'b000};
  assign w_half_sh   = {r_addr[1], 4'b0000};

  // Alignment legality of the incoming request
  always_comb begin
    w_legal = 1'b0;
    case (i_req_size)
      2'b00:   w_legal = 1'b1;
      2'b01:   w_legal = ~i_req_addr[0];
      2'b10:   w_legal = (i_req_addr[1:0] == 2'b00);
      default: w_legal = 1'b0;
    endcase
  end

  // Lane select and sign/zero extension of the read word
  always_comb begin
    w_byte = i_mem_rdata[w_byte_sh +: 8];
    w_half = i_mem_rdata[w_half_sh +: 16];
    case (r_size)
      2'b00:   w_ext = {{24{r_signed & w_byte[7]}}, w_byte};
      2'b01:   w_ext = {{16{r_signed & w_half[15]}}, w_half};
      default: w_ext = i_mem_rdata;
    endcase
  end

  // Replace the target lane(s) of the read word with store data
  always_comb begin
    w_merge = i_mem_rdata;
    if (r_size == 2'b00) begin
      w_merge[w_byte_sh +: 8] = r_wdata[7:0];
    end else begin
      w_merge[w_half_sh +: 16] = r_wdata[15:0];
    end
  end

  // Next-state decode
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (!w_legal)               w_next = S_FAULT;
          else if (!i_req_is_store)   w_next = S_LD_READ;
          else if (i_req_size == 2'b10) w_next = S_ST_WRITE;
          else                        w_next = S_RMW_READ;
        end
      end
      S_LD_READ:    w_next = S_LD_EXTRACT;
      S_LD_EXTRACT: w_next = S_IDLE;
      S_ST_WRITE:   w_next = S_IDLE;
      S_RMW_READ:   w_next = S_RMW_WRITE;
      S_RMW_WRITE:  w_next = S_IDLE;
      S_FAULT:      w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
  end

  // State, request capture, load result and completion pulses
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_addr       <= '0;
      r_size       <= 2'b00;
      r_signed     <= 1'b0;
      r_wdata      <= 32'h0;
      r_load_valid <= 1'b0;
      r_store_done <= 1'b0;
      r_load_data  <= 32'h0;
    end else begin
      r_state      <= w_next;
      r_load_valid <= (r_state == S_LD_EXTRACT);
      r_store_done <= (r_state == S_ST_WRITE) |
                      (r_state == S_RMW_WRITE);
      if (w_accept) begin
        r_addr   <= i_req_addr;
        r_size   <= i_req_size;
        r_signed <= i_req_signed;
        r_wdata  <= i_req_wdata;
      end
      if (r_state == S_LD_EXTRACT) begin
        r_load_data <= w_ext;
      end
    end
  end

  assign o_load_valid  = r_load_valid;
  assign o_store_done  = r_store_done;
  assign o_load_data   = r_load_data;
  assign o_align_fault = (r_state == S_FAULT) & ~i_rst;
  assign o_mem_addr    = r_addr[ADDR_W-1:2];
  assign o_mem_wdata   = (r_state == S_RMW_WRITE) ? w_merge : r_wdata;
  assign o_mem_read    = ~i_rst & ((r_state == S_LD_READ) |
                                   (r_state == S_RMW_READ));
  assign o_mem_write   = ~i_rst & ((r_state == S_ST_WRITE) |
                                   (r_state == S_RMW_WRITE));

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit with a behavioural 64x32 memory.
// Directed vector table plus reset-abort and back-to-back sequences.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [7:0]  req_addr = 8'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        load_valid;
  logic [31:0] load_data;
  logic        store_done;
  logic        align_fault;
  logic [5:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata = 32'h0;

  logic [31:0] mem [64];

  int passed = 0;
  int total  = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;
  int both_cnt = 0;
  int multi_cnt = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(8)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req_valid    (req_valid),
    .o_req_ready    (req_ready),
    .i_req_is_store (req_is_store),
    .i_req_size     (req_size),
    .i_req_signed   (req_signed),
    .i_req_addr     (req_addr),
    .i_req_wdata    (req_wdata),
    .o_load_valid   (load_valid),
    .o_load_data    (load_data),
    .o_store_done   (store_done),
    .o_align_fault  (align_fault),
    .o_mem_addr     (mem_addr),
    .o_mem_wdata    (mem_wdata),
    .o_mem_read     (mem_read),
    .o_mem_write    (mem_write),
    .i_mem_rdata    (mem_rdata)
  );

  // Memory: registered read at posedge, write at negedge
  always @(posedge clk) if (mem_read) mem_rdata <= mem[mem_addr];
  always @(negedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

  // Access and pulse-overlap monitor
  always @(posedge clk) begin
    if (mem_read) rd_cnt <= rd_cnt + 1;
    if (mem_write) wr_cnt <= wr_cnt + 1;
    if (mem_read && mem_write) both_cnt <= both_cnt + 1;
    if (int'(load_valid) + int'(store_done) + int'(align_fault) > 1)
      multi_cnt <= multi_cnt + 1;
  end

  typedef struct {
    logic        st;
    logic [1:0]  sz;
    logic        sg;
    logic [7:0]  addr;
    logic [31:0] wd;
    int          kind;
    logic [31:0] exp_ld;
    int          idx;
    logic [31:0] exp_mem;
  } vec_t;

  vec_t v [16];
  vec_t bq [5];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic drive(input vec_t t);
    req_is_store = t.st;
    req_size     = t.sz;
    req_signed   = t.sg;
    req_addr     = t.addr;
    req_wdata    = t.wd;
  endtask

  function automatic int pulse_kind();
    if (load_valid)  return 0;
    if (store_done)  return 1;
    if (align_fault) return 2;
    return -1;
  endfunction

  task automatic run_req(input int n, input vec_t t);
    int got_k, got_kind, rd0, wr0, exp_k, exp_rd, exp_wr;
    bit ok;
    @(negedge clk);
    drive(t);
    req_valid = 1'b1;
    ok = 1'b0;
    for (int w = 0; w < 10; w++) begin
      if (req_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    chk($sformatf("v%0d accept", n), 32'(ok), 32'd1);
    @(posedge clk); #1;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    req_valid = 1'b0;
    got_k = 0;
    got_kind = -1;
    for (int k = 1; k <= 8; k++) begin
      if (pulse_kind() >= 0) begin
        got_k = k;
        got_kind = pulse_kind();
        break;
      end
      @(posedge clk); #1;
    end
    exp_k  = (t.kind == 0) ? 3 : (t.kind == 2) ? 1 :
             (t.sz == 2'b10) ? 2 : 3;
    exp_rd = (t.kind == 0) ? 1 :
             (t.kind == 1 && t.sz != 2'b10) ? 1 : 0;
    exp_wr = (t.kind == 1) ? 1 : 0;
    chk($sformatf("v%0d latency", n), 32'(got_k), 32'(exp_k));
    chk($sformatf("v%0d pulse", n), 32'(got_kind), 32'(t.kind));
    if (t.kind == 0)
      chk($sformatf("v%0d ldata", n), load_data, t.exp_ld);
    @(posedge clk); #1;
    chk($sformatf("v%0d width", n), 32'(pulse_kind()), 32'hFFFFFFFF);
    chk($sformatf("v%0d reads", n), 32'(rd_cnt - rd0), 32'(exp_rd));
    chk($sformatf("v%0d writes", n), 32'(wr_cnt - wr0), 32'(exp_wr));
    chk($sformatf("v%0d mem", n), mem[t.idx], t.exp_mem);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, np;
    bit take, seen;
    int kinds [5];
    logic [31:0] datas [5];
    int exp_kinds [5];
    logic [31:0] exp_datas [5];

    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[4] = 32'h11223344;

    v[0]  = '{1'b1, 2'b10, 1'b0, 8'h08, 32'hDEADBEEF, 1, 32'h0, 2, 32'hDEADBEEF};
    v[1]  = '{1'b0, 2'b10, 1'b0, 8'h08, 32'h0, 0, 32'hDEADBEEF, 2, 32'hDEADBEEF};
    v[2]  = '{1'b1, 2'b00, 1'b0, 8'h09, 32'h5A, 1, 32'h0, 2, 32'hDEAD5AEF};
    v[3]  = '{1'b0, 2'b00, 1'b1, 8'h0B, 32'h0, 0, 32'hFFFFFFDE, 2, 32'hDEAD5AEF};
    v[4]  = '{1'b0, 2'b00, 1'b0, 8'h0B, 32'h0, 0, 32'h000000DE, 2, 32'hDEAD5AEF};
    v[5]  = '{1'b1, 2'b01, 1'b0, 8'h0A, 32'h8001, 1, 32'h0, 2, 32'h80015AEF};
    v[6]  = '{1'b0, 2'b01, 1'b1, 8'h0A, 32'h0, 0, 32'hFFFF8001, 2, 32'h80015AEF};
    v[7]  = '{1'b0, 2'b01, 1'b0, 8'h0A, 32'h0, 0, 32'h00008001, 2, 32'h80015AEF};
    v[8]  = '{1'b0, 2'b00, 1'b1, 8'h08, 32'h0, 0, 32'hFFFFFFEF, 2, 32'h80015AEF};
    v[9]  = '{1'b0, 2'b00, 1'b0, 8'h09, 32'h0, 0, 32'h0000005A, 2, 32'h80015AEF};
    v[10] = '{1'b0, 2'b01, 1'b1, 8'h08, 32'h0, 0, 32'h00005AEF, 2, 32'h80015AEF};
    v[11] = '{1'b0, 2'b01, 1'b0, 8'h05, 32'h0, 2, 32'h0, 1, 32'h0};
    v[12] = '{1'b1, 2'b10, 1'b0, 8'h0E, 32'h12345678, 2, 32'h0, 3, 32'h0};
    v[13] = '{1'b1, 2'b11, 1'b0, 8'h08, 32'hFFFFFFFF, 2, 32'h0, 2, 32'h80015AEF};
    v[14] = '{1'b1, 2'b00, 1'b0, 8'h0C, 32'hFFFFFF77, 1, 32'h0, 3, 32'h00000077};
    v[15] = '{1'b0, 2'b10, 1'b0, 8'h0C, 32'h0, 0, 32'h00000077, 3, 32'h00000077};

    bq[0] = '{1'b0, 2'b10, 1'b0, 8'h08, 32'h0, 0, 32'h80015AEF, 2, 32'h0};
    bq[1] = '{1'b1, 2'b10, 1'b0, 8'h14, 32'hCAFEF00D, 1, 32'h0, 5, 32'h0};
    bq[2] = '{1'b0, 2'b10, 1'b0, 8'h14, 32'h0, 0, 32'hCAFEF00D, 5, 32'h0};
    bq[3] = '{1'b1, 2'b00, 1'b0, 8'h15, 32'h99, 1, 32'h0, 5, 32'h0};
    bq[4] = '{1'b0, 2'b10, 1'b0, 8'h14, 32'h0, 0, 32'hCAFE990D, 5, 32'h0};

    // Reset state
    @(negedge clk);
    chk("rst ready", 32'(req_ready), 32'd0);
    chk("rst mem_read", 32'(mem_read), 32'd0);
    chk("rst mem_write", 32'(mem_write), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post-rst ready", 32'(req_ready), 32'd1);
    chk("post-rst ldata", load_data, 32'h0);
    chk("post-rst pulses", 32'(pulse_kind()), 32'hFFFFFFFF);

    for (int i = 0; i < 16; i++) run_req(i, v[i]);

    // Reset during RMW_WRITE of a byte store to word 4
    @(negedge clk);
    req_is_store = 1'b1;
    req_size = 2'b00;
    req_signed = 1'b0;
    req_addr = 8'h10;
    req_wdata = 32'hAB;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("abort rmw_read", 32'(mem_read), 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort mem_write", 32'(mem_write), 32'd0);
    chk("abort ready", 32'(req_ready), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("abort ready after", 32'(req_ready), 32'd1);
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (store_done) seen = 1'b1;
      @(posedge clk); #1;
    end
    chk("abort no done", 32'(seen), 32'd0);
    chk("abort mem4", mem[4], 32'h11223344);

    // Back-to-back traffic with ReqValid held
    acc = 0;
    np = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (acc < 5) begin
        drive(bq[acc]);
        req_valid = 1'b1;
      end else begin
        req_valid = 1'b0;
      end
      take = req_valid && req_ready;
      @(posedge clk); #1;
      if (take) acc++;
      if (pulse_kind() >= 0) begin
        if (np < 5) begin
          kinds[np] = pulse_kind();
          datas[np] = load_data;
        end
        np++;
      end
    end
    chk("b2b accepts", 32'(acc), 32'd5);
    chk("b2b pulses", 32'(np), 32'd5);
    for (int i = 0; i < 5; i++) begin
      exp_kinds[i] = bq[i].kind;
      exp_datas[i] = bq[i].exp_ld;
    end
    for (int i = 0; i < 5 && i < np; i++) begin
      chk($sformatf("b2b%0d kind", i), 32'(kinds[i]), 32'(exp_kinds[i]));
      if (exp_kinds[i] == 0)
        chk($sformatf("b2b%0d ldata", i), datas[i], exp_datas[i]);
    end
    chk("b2b mem5", mem[5], 32'hCAFE990D);

    chk("never rd&wr", 32'(both_cnt), 32'd0);
    chk("pulse overlap", 32'(multi_cnt), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage front end that sits directly upstream of the 64x32 word data memory.
- Accepts one byte, halfword or word load or store per transaction from the EX/MEM pipeline register and converts its byte address to a word index.
- Performs read-modify-write for sub-word stores, and extracts and sign- or zero-extends loaded data.
- Memory timing: the memory registers ReadData at posedge when MemRead=1, and writes at negedge when MemWrite=1.

Parameters:
- ADDR_W, 8, byte-address width; word index width is ADDR_W-2 (6 for the 64-word memory).

Ports:
- Clock  in  1  single clock, rising-edge; all state updates on posedge.
- Reset  in  1  synchronous, active-high.
- ReqValid  in  1  request present.
- ReqReady  out  1  unit can accept a request this cycle.
- ReqIsStore  in  1  1=store, 0=load.
- ReqSize  in  2  00=byte, 01=halfword, 10=word, 11=illegal.
- ReqSigned  in  1  loads only: 1=sign-extend, 0=zero-extend.
- ReqAddr  in  ADDR_W  byte address.
- ReqWriteData  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- LoadValid  out  1  one-cycle pulse; LoadData valid.
- LoadData  out  32  extended load result.
- StoreDone  out  1  one-cycle pulse; store committed.
- AlignFault  out  1  one-cycle pulse; request rejected.
- MemAddress  out  ADDR_W-2  word index to memory.
- MemWriteData  out  32  word to memory.
- MemRead  out  1  memory read enable.
- MemWrite  out  1  memory write enable.
- MemReadData  in  32  memory ReadData (registered inside memory).

Behaviour:
- States: IDLE, LD_READ, LD_EXTRACT, ST_WRITE, RMW_READ, RMW_WRITE, FAULT.
- Reset (sampled at posedge):
  - state=IDLE.
  - LoadValid=StoreDone=AlignFault=0; LoadData=0.
  - Captured address, size, signed and data registers=0.
  - Any in-flight transaction is abandoned and produces no pulse.
- Reset also combinationally forces ReqReady=0, MemRead=0, MemWrite=0 in any cycle where Reset=1. No memory access occurs during reset, even in a write state.
- ReqReady = (state==IDLE) & !Reset. A request is accepted at the posedge where ReqValid & ReqReady; ReqAddr, ReqSize, ReqSigned and ReqWriteData are captured at that edge.
- Byte lanes are little-endian: offset = addr[1:0]; lane k occupies bits [8k+7:8k]. MemAddress = captured addr[ADDR_W-1:2].
- Alignment:
  - Halfword requires addr[0]=0; word requires addr[1:0]=00; ReqSize=11 is always illegal.
  - Illegal requests go IDLE->FAULT. In FAULT, AlignFault=1 for 1 cycle with no memory access, then FAULT->IDLE.
- Load:
  - IDLE->LD_READ: MemRead=1; the memory captures at the closing edge.
  - LD_READ->LD_EXTRACT: select the lane(s) of MemReadData by offset and extend per size/signed; LoadData is registered at the closing edge.
  - LD_EXTRACT->IDLE with LoadValid=1 in that first IDLE cycle.
  - Latency is 3 cycles from the accept edge to the LoadValid cycle. A new request may be accepted in the LoadValid cycle.
- Word store: IDLE->ST_WRITE: MemWrite=1, MemWriteData=captured data, 1 cycle. Then ->IDLE with StoreDone=1 in the first IDLE cycle.
- Sub-word store:
  - IDLE->RMW_READ: MemRead=1.
  - ->RMW_WRITE: MemWrite=1, MemWriteData=MemReadData with the target lane(s) replaced by captured data[7:0] or [15:0]; other lanes are unchanged.
  - ->IDLE with StoreDone=1.
- MemRead and MemWrite are never both 1. Both are 0 in IDLE and FAULT. They are decoded from the state register only, never from request inputs.
- Outputs are stable between posedges. MemWriteData and MemAddress are held constant for the whole write cycle, which covers the memory's negedge write.
- ReqValid while busy is ignored; the requester must hold the request until ReqReady.
- Pulse outputs are mutually exclusive and last exactly 1 cycle.

Test Plan:
- Reset, then word store addr=0x08, data=0xDEADBEEF -> MemWrite=1 for 1 cycle with MemAddress=2; StoreDone pulses. Then load word addr=0x08 -> LoadValid exactly 3 cycles after accept, LoadData=0xDEADBEEF.
- Memory word 2 = 0xDEADBEEF; store byte 0x5A at addr=0x09 -> MemRead cycle, then MemWrite with data 0xDEAD5AEF. Load byte signed at 0x0B -> 0xFFFFFFDE; unsigned -> 0x000000DE.
- Word 2 = 0xDEAD5AEF; store half 0x8001 at addr=0x0A -> memory word 0x80015AEF. Load half signed at 0x0A -> 0xFFFF8001; unsigned -> 0x00008001.
- Half load at addr=0x05, word store at addr=0x0E, and ReqSize=11 -> each gives AlignFault for 1 cycle; MemRead and MemWrite stay 0; memory is unchanged.
- Assert Reset for 1 cycle during RMW_WRITE of a byte store to addr=0x10 (word 4 = 0x11223344) -> MemWrite=0 that cycle; word 4 stays 0x11223344; no StoreDone; ReqReady=1 the cycle after reset deasserts.
- Back-to-back traffic: hold ReqValid with 5 alternating loads and stores -> each accepted only in IDLE; no request lost or duplicated; pulses match the issue order.
